// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings plus
// the bit positions of the flag vector.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_XOR = 4'd3,
    OP_SUB = 4'd4,
    OP_SRL = 4'd5,
    OP_SLL = 4'd6,
    OP_NOR = 4'd7,
    OP_SRA = 4'd8,
    OP_SLT = 4'd9,
    OP_MUL = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_NEG   = 3;
  localparam int FLG_ERR   = 4;
  localparam int NFLAGS    = 5;

  typedef logic [NFLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_seq_core.sv
// Single-cycle combinational datapath: every opcode except MUL, plus flags.
// MUL yields zero here; the parent builds its product iteratively.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_res,
  output flags_t           o_flags
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_sh;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[SHW-1:0];

  always_comb begin
    o_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (i_op)
      OP_AND: o_res = i_a & i_b;
      OP_OR:  o_res = i_a | i_b;
      OP_ADD: begin
        o_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_XOR: o_res = i_a ^ i_b;
      OP_SUB: begin
        // Carry on subtract means "no borrow", i.e. a >= b unsigned.
        o_res   = w_diff[WIDTH-1:0];
        w_carry = ~w_diff[WIDTH];
        w_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SRL: o_res = i_a >> w_sh;
      OP_SLL: o_res = i_a << w_sh;
      OP_NOR: o_res = ~(i_a | i_b);
      OP_SRA: o_res = $signed(i_a) >>> w_sh;
      OP_SLT: o_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_MUL: o_res = '0;
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    o_flags            = '0;
    o_flags[FLG_ZERO]  = (o_res == '0);
    o_flags[FLG_CARRY] = w_carry;
    o_flags[FLG_OVF]   = w_ovf;
    o_flags[FLG_NEG]   = o_res[WIDTH-1];
    o_flags[FLG_ERR]   = w_err;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle ops via alu_seq_core,
// MUL as a one-bit-per-cycle shift-add, result held until the consumer takes it.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ZERO,
  output logic             CARRY,
  output logic             OVF,
  output logic             NEG,
  output logic             ERR
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_res_core;
  flags_t           w_flags_core;
  logic [WIDTH-1:0] w_acc_nxt;
  flags_t           w_flags_mul;
  logic             w_is_mul;
  logic             w_mul_last;
  logic             w_ld_core;
  logic             w_start_mul;
  logic             w_drop;

  alu_seq_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .i_a     (a),
    .i_b     (b),
    .i_op    (opCode),
    .o_res   (w_res_core),
    .o_flags (w_flags_core)
  );

  assign w_is_mul   = (opCode == OP_MUL);
  assign w_mul_last = (r_state == S_EXEC) && (r_cnt == SHW'(WIDTH - 1));
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_flags_mul           = '0;
    w_flags_mul[FLG_ZERO] = (w_acc_nxt == '0);
    w_flags_mul[FLG_NEG]  = w_acc_nxt[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    in_ready    = 1'b0;
    w_state_nxt = r_state;
    w_ld_core   = 1'b0;
    w_start_mul = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_EXEC: if (w_mul_last) w_state_nxt = S_HOLD;
      S_HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (in_valid && in_ready) begin
      if (w_is_mul) begin
        w_start_mul = 1'b1;
        w_state_nxt = S_EXEC;
      end else begin
        w_ld_core   = 1'b1;
        w_drop      = 1'b0;
        w_state_nxt = S_HOLD;
      end
    end
  end

  // The acceptance edge already consumes multiplier bit 0, so the last of the
  // WIDTH steps lands the product WIDTH cycles after acceptance, counted the
  // same way as the latency-1 single-cycle ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_start_mul) begin
      r_acc    <= b[0] ? a : '0;
      r_mcand  <= a << 1;
      r_mplier <= b >> 1;
      r_cnt    <= SHW'(1);
    end else if (r_state == S_EXEC) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_ld_core) begin
      r_result    <= w_res_core;
      r_flags     <= w_flags_core;
      r_out_valid <= 1'b1;
    end else if (w_mul_last) begin
      r_result    <= w_acc_nxt;
      r_flags     <= w_flags_mul;
      r_out_valid <= 1'b1;
    end else if (w_drop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ZERO      = r_flags[FLG_ZERO];
  assign CARRY     = r_flags[FLG_CARRY];
  assign OVF       = r_flags[FLG_OVF];
  assign NEG       = r_flags[FLG_NEG];
  assign ERR       = r_flags[FLG_ERR];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vectors, MUL timing,
// hold/back-to-back handshake, mid-operation reset and randomized ops.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  opCode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ZERO, CARRY, OVF, NEG, ERR;
  logic [36:0] obs;

  int errors = 0;
  int checks = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opCode    (opCode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ZERO      (ZERO),
    .CARRY     (CARRY),
    .OVF       (OVF),
    .NEG       (NEG),
    .ERR       (ERR)
  );

  assign obs = {result, ZERO, CARRY, OVF, NEG, ERR};

  // Reference: {result, ZERO, CARRY, OVF, NEG, ERR} from plain integer arithmetic.
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        c, o, e;
    longint      sx, sy, s;
    logic [63:0] p;
    r = '0; c = 1'b0; o = 1'b0; e = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  begin
        s = sx + sy; r = x + y;
        c = ({32'h0, x} + {32'h0, y}) > 64'hFFFF_FFFF;
        o = (s > SMAX) || (s < SMIN);
      end
      4'd3:  r = x ^ y;
      4'd4:  begin
        s = sx - sy; r = x - y;
        c = (x >= y);
        o = (s > SMAX) || (s < SMIN);
      end
      4'd5:  r = x >> y[4:0];
      4'd6:  r = x << y[4:0];
      4'd7:  r = ~(x | y);
      4'd8:  begin s = sx >>> y[4:0]; r = s[31:0]; end
      4'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd10: begin p = {32'h0, x} * {32'h0, y}; r = p[31:0]; end
      default: e = 1'b1;
    endcase
    return {r, (r == 32'h0), c, o, r[31], e};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opCode = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, obs} !== 38'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {out_valid, obs});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  t_op [7] = '{4'd2, 4'd4, 4'd8, 4'd15, 4'd9, 4'd6, 4'd4};
    logic [31:0] t_a  [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678,
                              32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0005};
    logic [31:0] t_b  [7] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0024, 32'h9ABC_DEF0,
                              32'h0000_0001, 32'h0000_0021, 32'h0000_0007};
    logic [36:0] t_x  [7] = '{{32'h0000_0000, 5'b11000}, {32'h7FFF_FFFF, 5'b01100},
                              {32'hF800_0000, 5'b00010}, {32'h0000_0000, 5'b10001},
                              {32'h0000_0001, 5'b00000}, {32'h0000_0002, 5'b00000},
                              {32'hFFFF_FFFE, 5'b00010}};
    int lat;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opCode = t_op[i]; a = t_a[i]; b = t_b[i]; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; opCode = 4'($urandom_range(0, 15));
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      checks++;
      if (lat !== 1) begin
        errors++; $display("FAIL directed_latency[%0d]: got %0d expected 1", i, lat);
      end
      checks++;
      if (obs !== t_x[i]) begin
        errors++; $display("FAIL directed_value[%0d]: got %h expected %h", i, obs, t_x[i]);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL directed_retire[%0d]: got %b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_mul();
    int lat;
    logic busy_bad;
    busy_bad = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; opCode = 4'd10; a = 32'h7; b = 32'h6; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      @(negedge clk); lat++;
    end
    checks++;
    if (busy_bad !== 1'b0) begin
      errors++; $display("FAIL mul_in_ready_busy: got 1 during EXEC expected 0");
    end
    checks++;
    if (lat !== 32) begin
      errors++; $display("FAIL mul_latency: got %0d expected 32", lat);
    end
    checks++;
    if (obs !== {32'h0000_002A, 5'b00000}) begin
      errors++; $display("FAIL mul_value: got %h expected %h", obs, {32'h0000_002A, 5'b00000});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa, xb, oa, ob;
    logic [36:0] exp;
    logic        bad;
    logic [3:0]  cop [3];
    logic [31:0] ca [3], cb [3];
    xa = $urandom; xb = $urandom; oa = $urandom; ob = $urandom;
    @(negedge clk);
    in_valid = 1'b1; opCode = 4'd3; a = xa; b = xb; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    exp = model(4'd3, xa, xb);
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (out_valid !== 1'b1 || obs !== exp || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0 || obs !== exp) begin
      errors++; $display("FAIL hold_stable: got v=%b %h expected v=1 %h", out_valid, obs, exp);
    end
    out_ready = 1'b1; in_valid = 1'b1; opCode = 4'd1; a = oa; b = ob;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp = model(4'd1, oa, ob);
    checks++;
    if ({out_valid, obs} !== {1'b1, exp}) begin
      errors++; $display("FAIL b2b_or: got %h expected %h", {out_valid, obs}, {1'b1, exp});
    end
    for (int k = 0; k < 3; k++) begin
      cop[k] = 4'($urandom_range(0, 9)); ca[k] = $urandom; cb[k] = $urandom;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; opCode = cop[k]; a = ca[k]; b = cb[k];
      @(negedge clk);
      exp = model(cop[k], ca[k], cb[k]);
      checks++;
      if ({out_valid, obs} !== {1'b1, exp}) begin
        errors++; $display("FAIL b2b_chain[%0d]: got %h expected %h", k, {out_valid, obs}, {1'b1, exp});
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int quiet_bad;
    @(negedge clk);
    in_valid = 1'b1; opCode = 4'd10; a = 32'h1234_5677; b = 32'h0000_0F0F; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, obs} !== 38'h0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", {out_valid, obs});
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; opCode = 4'd2; a = 32'd2; b = 32'd3;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, obs} !== {1'b1, 32'h0000_0005, 5'b00000}) begin
      errors++; $display("FAIL reset_add: got %h expected %h", {out_valid, obs}, {1'b1, 32'h5, 5'b0});
    end
    quiet_bad = 0;
    @(negedge clk);
    repeat (40) begin
      if (out_valid !== 1'b0) quiet_bad++;
      @(negedge clk);
    end
    checks++;
    if (quiet_bad !== 0) begin
      errors++; $display("FAIL reset_no_stale: got %0d valid cycles expected 0", quiet_bad);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] ra, rb;
    logic [36:0] exp;
    int lat, want;
    for (int i = 0; i < 40; i++) begin
      op = (i % 8 == 7) ? 4'd10 : 4'($urandom_range(0, 15));
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) rb = ra;
      @(negedge clk);
      in_valid = 1'b1; opCode = op; a = ra; b = rb; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      want = (op == 4'd10) ? 32 : 1;
      exp = model(op, ra, rb);
      checks++;
      if (lat !== want || obs !== exp) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d %h expected lat=%0d %h",
                 i, op, ra, rb, lat, obs, want, exp);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; legal range 8..64 and a power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH): derived shift-amount width; not overridden by users.
REQ-003 clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 in_valid, input, 1: the operation on a/b/opCode is presented.
REQ-006 in_ready, output, 1: the block accepts an operation this cycle.
REQ-007 a, input, WIDTH: operand A.
REQ-008 b, input, WIDTH: operand B; bits [SHW-1:0] are the shift amount for shift ops.
REQ-009 opCode, input, 4: operation select.
REQ-010 out_valid, output, 1: result and flags are valid.
REQ-011 out_ready, input, 1: the consumer takes the result.
REQ-012 result, output, WIDTH: registered result.
REQ-013 ZERO, CARRY, OVF, NEG, ERR, output, 1 each: registered flags.

Function
REQ-014 Opcodes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SUB (a-b), 5 SRL, 6 SLL, 7 NOR, 8 SRA, 9 SLT signed (result 1/0), 10 MUL (low WIDTH bits of the product); 11-15 are illegal.
REQ-015 Acceptance: a transfer occurs on an edge where in_valid && in_ready; a, b and opCode are captured at that edge, and later changes are ignored.
REQ-016 FSM states are IDLE, EXEC and HOLD; reset enters IDLE.
REQ-017 in_ready is 1 in IDLE, 1 in HOLD when out_ready=1, and 0 in EXEC or in HOLD when out_ready=0.
REQ-018 For a non-MUL op (including illegal), acceptance moves the FSM to HOLD, and result, flags and out_valid=1 appear on the edge after acceptance (latency 1).
REQ-019 MUL moves the FSM to EXEC and runs an iterative shift-add of one multiplier bit per cycle for WIDTH cycles; out_valid rises exactly WIDTH cycles after the acceptance edge.
REQ-020 In HOLD with out_ready=0, result, flags and out_valid hold stable.
REQ-021 In HOLD with out_ready=1 and no new transfer, out_valid drops on the next edge and the FSM returns to IDLE.
REQ-022 In HOLD with out_ready=1 and a new transfer (back-to-back), the old result retires and the new op proceeds per REQ-018/019; for a non-MUL op, out_valid stays 1 with the new result next cycle.
REQ-023 ZERO = (result == 0) for all ops, and NEG = result[WIDTH-1].
REQ-024 CARRY is the carry-out for ADD, the no-borrow flag (a >= b unsigned) for SUB, and 0 for other ops.
REQ-025 OVF is signed overflow for ADD/SUB and 0 for other ops; MUL overflow is not flagged.
REQ-026 Illegal opcodes produce result=0, ZERO=1, ERR=1 and all other flags 0; ERR=0 for legal opcodes.
REQ-027 Shifts use only b[SHW-1:0], and upper bits of b are ignored; SRA replicates a[WIDTH-1].

Reset
REQ-028 rst_n low forces IDLE, result=0, out_valid=0, all flags 0, and clears the MUL accumulator and counter, with effect immediately and independent of clk.
REQ-029 Reset during EXEC or HOLD abandons the operation with no output produced; in_ready=1 on the first edge after rst_n rises.

Structure
REQ-030 Package alu_seq_pkg holds the opcode enum (4 bits), the FSM state enum and the flag-index constants.
REQ-031 One sub-module, alu_seq_core, holds the purely combinational single-cycle datapath (ops 0-9 plus flags), parametrised by WIDTH; MUL iteration and the FSM live in alu_seq.

Verification (WIDTH=32)
REQ-032 ADD a=FFFFFFFF, b=00000001 -> next cycle result=0, ZERO=1, CARRY=1, OVF=0, out_valid=1.
REQ-033 SUB a=80000000, b=00000001 -> result=7FFFFFFF, OVF=1, CARRY=1, NEG=0.
REQ-034 MUL a=00000007, b=00000006 -> in_ready=0 for the whole of EXEC, and out_valid rises exactly 32 cycles after acceptance with result=0000002A.
REQ-035 Hold out_ready=0 for 3 cycles after an XOR result -> result and flags stay stable; then out_ready=1 with a new OR issued the same cycle -> out_valid stays 1 and the OR result appears next cycle.
REQ-036 rst_n pulsed low 10 cycles into a MUL -> all outputs 0 at once, and after release an ADD 2+3 returns 00000005 with latency 1.
REQ-037 SRA a=80000000, b=00000024 -> F8000000; opCode=15 -> result=0, ZERO=1, ERR=1.
